// File: rtl/countdown_timer.sv
// Loadable down-counter with one-cycle underflow pulse on expiry.
// It supports one-shot and periodic (auto-reload) operation.
module countdown_timer #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             periodic,
  output logic [WIDTH-1:0] out,
  output logic             underflow,
  output logic             busy
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] rl;

  // Priority per edge: rst > load > en; out==0 while running is the expiry step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      out       <= '0;
      rl        <= '0;
      underflow <= 1'b0;
      busy      <= 1'b0;
    end else if (load) begin
      out       <= load_val;
      rl        <= load_val;
      underflow <= 1'b0;
      if (load_val != '0) begin
        state <= RUN;
        busy  <= 1'b1;
      end else begin
        state <= IDLE;
        busy  <= 1'b0;
      end
    end else if (state == RUN && en) begin
      if (out != '0) begin
        out       <= out - WIDTH'(1);
        underflow <= 1'b0;
      end else begin
        underflow <= 1'b1;
        if (periodic) begin
          out <= rl;
        end else begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      end
    end else begin
      underflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer with hand-computed expectations.
module tb_countdown_timer;

  localparam int unsigned WIDTH = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             periodic;
  logic [WIDTH-1:0] out;
  logic             underflow;
  logic             busy;

  int total = 0;
  int bad   = 0;

  countdown_timer #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .en(en), .load(load), .load_val(load_val),
    .periodic(periodic), .out(out), .underflow(underflow), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Advance one rising edge and sample 1ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [WIDTH-1:0] v);
    load = 1'b1;
    load_val = v;
    tick();
    load = 1'b0;
  endtask

  initial begin
    int exp_out [7];
    int exp_uf  [7];
    int first_uf, second_uf, uf_cnt, k;

    rst = 1'b1; en = 1'b0; load = 1'b0; load_val = '0; periodic = 1'b0;
    #12;
    check("rst_out", int'(out), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_uf", int'(underflow), 0);
    rst = 1'b0;
    tick();

    // One-shot: load 3, en held high
    periodic = 1'b0; en = 1'b1;
    do_load(4'd3);
    check("os_e0_out", int'(out), 3);
    check("os_e0_busy", int'(busy), 1);
    for (int i = 1; i <= 3; i++) begin
      tick();
      check($sformatf("os_e%0d_out", i), int'(out), 3 - i);
      check($sformatf("os_e%0d_uf", i), int'(underflow), 0);
    end
    tick();
    check("os_e4_uf", int'(underflow), 1);
    check("os_e4_busy", int'(busy), 0);
    check("os_e4_out", int'(out), 0);
    tick();
    check("os_e5_uf", int'(underflow), 0);
    check("os_e5_out", int'(out), 0);

    // Periodic: load 2 -> 2,1,0,2,1,0,2 with pulses on reload edges
    exp_out = '{2, 1, 0, 2, 1, 0, 2};
    exp_uf  = '{0, 0, 0, 1, 0, 0, 1};
    periodic = 1'b1; en = 1'b1;
    do_load(4'd2);
    for (int i = 0; i < 7; i++) begin
      if (i > 0) tick();
      check($sformatf("per2_e%0d_out", i), int'(out), exp_out[i]);
      check($sformatf("per2_e%0d_uf", i), int'(underflow), exp_uf[i]);
      check($sformatf("per2_e%0d_busy", i), int'(busy), 1);
    end

    // Periodic: load 15 -> pulses at edges 16 and 32 after the load edge
    do_load(4'd15);
    check("per15_e0_out", int'(out), 15);
    first_uf = -1; second_uf = -1; uf_cnt = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (underflow) begin
        uf_cnt++;
        if (first_uf < 0) first_uf = i;
        else if (second_uf < 0) second_uf = i;
      end
      if (i == 15) check("per15_e15_out", int'(out), 0);
      if (i == 16) check("per15_e16_out", int'(out), 15);
    end
    check("per15_first", first_uf, 16);
    check("per15_gap", second_uf - first_uf, 16);
    check("per15_count", uf_cnt, 2);

    // Enable gaps: load 4 one-shot, en alternates 1,0,...
    periodic = 1'b0;
    do_load(4'd4);
    k = 0;
    for (int i = 0; i < 12; i++) begin
      en = (i % 2 == 0);
      tick();
      if (en) k++;
      check($sformatf("gap_i%0d_out", i), int'(out), (k >= 4) ? 0 : 4 - k);
      check($sformatf("gap_i%0d_uf", i), int'(underflow), (en && k == 5) ? 1 : 0);
      check($sformatf("gap_i%0d_busy", i), int'(busy), (k >= 5) ? 0 : 1);
    end

    // Load precedence over decrement and over expiry
    periodic = 1'b1; en = 1'b1;
    do_load(4'd2);
    tick();
    check("prec_pre_out", int'(out), 1);
    do_load(4'd7);
    check("prec_load7_out", int'(out), 7);
    check("prec_load7_uf", int'(underflow), 0);
    for (int i = 0; i < 7; i++) tick();
    check("prec_at0_out", int'(out), 0);
    do_load(4'd6);
    check("prec_load6_out", int'(out), 6);
    check("prec_load6_uf", int'(underflow), 0);
    check("prec_load6_busy", int'(busy), 1);
    tick();
    check("prec_after_out", int'(out), 5);

    // Zero load: never underflows, stays idle regardless of periodic
    for (int p = 0; p < 2; p++) begin
      periodic = p[0];
      en = 1'b1;
      do_load(4'd0);
      uf_cnt = 0;
      for (int i = 0; i < 20; i++) begin
        if (underflow || busy || out != '0) uf_cnt++;
        tick();
      end
      check($sformatf("zero_p%0d_anyactive", p), uf_cnt, 0);
    end

    // Asynchronous reset mid-count
    en = 1'b0; periodic = 1'b0;
    do_load(4'd5);
    check("ar_pre_out", int'(out), 5);
    check("ar_pre_busy", int'(busy), 1);
    #2;
    rst = 1'b1;
    #1;
    check("ar_async_out", int'(out), 0);
    check("ar_async_busy", int'(busy), 0);
    check("ar_async_uf", int'(underflow), 0);
    en = 1'b1;
    tick();
    tick();
    check("ar_hold_out", int'(out), 0);
    check("ar_hold_busy", int'(busy), 0);
    check("ar_hold_uf", int'(underflow), 0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    check("ar_idle_out", int'(out), 0);
    check("ar_idle_busy", int'(busy), 0);
    check("ar_idle_uf", int'(underflow), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
